pulse_id_keeper: RTL and testbench

//  Owns the 64-bit pulse-ID counter of the transmitter. It sits directly upstream of the MRAM store
//  and drives its start/write/data handshake. After reset it restores the last stored pulse-ID from

---
 rtl/pulse_id_keeper.sv | 137 +++++++++++++
 tb/tb_pulse_id_keeper.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_id_keeper.sv
// pulse_id_keeper
//   Owns the 64-bit pulse-ID counter. After reset it reads the last stored
//   value back from the MRAM store, adds BOOT_SKIP and resumes from there.
//   Every accepted tick/load marks the counter dirty, and the latest value
//   is written back to MRAM so an ID is never reissued after a reboot.
//
// Ports
//   clk                     in   1   system clock
//   reset                   in   1   synchronous, active-high
//   tick                    in   1   100 Hz strobe, one clk wide
//   load                    in   1   overwrite counter with load_value
//   load_value              in   64  value for load
//   pulse_id                out  64  current pulse-ID
//   pulse_id_valid          out  1   restore from MRAM has completed
//   overrun                 out  1   sticky: tick/load while a write was still pending
//   mram_start              out  1   MRAM operation start
//   mram_write              out  1   MRAM direction (1=write, 0=read)
//   mram_ready              in   1   MRAM idle
//   mram_pulse_id_to_write  out  64  MRAM write data, stable for the whole write
//   mram_pulse_id_read      in   64  MRAM read data, valid when ready returns
module pulse_id_keeper #(
    parameter logic [63:0] BOOT_SKIP    = 64'd1,
    parameter logic [63:0] ERASED_VALUE = '1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        load,
    input  logic [63:0] load_value,
    output logic [63:0] pulse_id,
    output logic        pulse_id_valid,
    output logic        overrun,
    output logic        mram_start,
    output logic        mram_write,
    input  logic        mram_ready,
    output logic [63:0] mram_pulse_id_to_write,
    input  logic [63:0] mram_pulse_id_read
);

    typedef enum logic [2:0] {
        BOOT_WAIT,
        RD_ISSUE,
        RD_BUSY,
        RD_DONE,
        IDLE,
        WR_ISSUE,
        WR_BUSY,
        WR_DONE
    } state_t;

    state_t      state_q;
    logic [63:0] pulse_id_q;
    logic [63:0] wr_data_q;
    logic        valid_q;
    logic        overrun_q;
    logic        pending_q;

    logic        upd;
    logic [63:0] pulse_id_d;
    logic [63:0] restore_base;
    logic [63:0] restore_d;

    // Counter updates are only accepted once the restored value is in place;
    // load takes precedence over a simultaneous tick.
    always_comb begin
        upd        = valid_q && (tick || load);
        pulse_id_d = pulse_id_q;
        if (upd) begin
            pulse_id_d = load ? load_value : (pulse_id_q + 64'd1);
        end
    end

    // A blank MRAM restores as if it had held zero.
    always_comb begin
        restore_base = (mram_pulse_id_read == ERASED_VALUE) ? 64'd0 : mram_pulse_id_read;
        restore_d    = restore_base + BOOT_SKIP;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT_WAIT;
            pulse_id_q <= 64'd0;
            wr_data_q  <= 64'd0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            pending_q  <= 1'b0;
        end else begin
            if (upd) begin
                pulse_id_q <= pulse_id_d;
                pending_q  <= 1'b1;
                if (pending_q) begin
                    overrun_q <= 1'b1;
                end
            end

            case (state_q)
                BOOT_WAIT: if (mram_ready)  state_q <= RD_ISSUE;
                RD_ISSUE:  if (mram_ready)  state_q <= RD_BUSY;
                RD_BUSY:   if (!mram_ready) state_q <= RD_DONE;
                RD_DONE: begin
                    if (mram_ready) begin
                        // Restored value is immediately queued for write-back.
                        pulse_id_q <= restore_d;
                        valid_q    <= 1'b1;
                        pending_q  <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                IDLE: begin
                    if (pending_q) begin
                        wr_data_q <= pulse_id_q;
                        state_q   <= WR_ISSUE;
                        // An update landing on this same edge keeps the
                        // request alive so the newer value follows.
                        if (!upd) begin
                            pending_q <= 1'b0;
                        end
                    end
                end
                WR_ISSUE:  if (mram_ready)  state_q <= WR_BUSY;
                WR_BUSY:   if (!mram_ready) state_q <= WR_DONE;
                WR_DONE:   if (mram_ready)  state_q <= IDLE;
                default:   state_q <= BOOT_WAIT;
            endcase
        end
    end

    // start is held only while the store reports idle in an ISSUE state.
    assign mram_start = mram_ready && ((state_q == RD_ISSUE) || (state_q == WR_ISSUE));
    assign mram_write = mram_ready && (state_q == WR_ISSUE);

    assign pulse_id               = pulse_id_q;
    assign pulse_id_valid         = valid_q;
    assign overrun                = overrun_q;
    assign mram_pulse_id_to_write = wr_data_q;

endmodule

// File: tb/tb_pulse_id_keeper.sv
module tb_pulse_id_keeper;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic        load = 1'b0;
    logic [63:0] load_value = 64'd0;
    logic [63:0] pulse_id;
    logic        pulse_id_valid;
    logic        overrun;
    logic        mram_start;
    logic        mram_write;
    logic        mram_ready;
    logic [63:0] mram_pulse_id_to_write;
    logic [63:0] mram_pulse_id_read;

    always #5 clk = ~clk;

    pulse_id_keeper dut (
        .clk                    (clk),
        .reset                  (reset),
        .tick                   (tick),
        .load                   (load),
        .load_value             (load_value),
        .pulse_id               (pulse_id),
        .pulse_id_valid         (pulse_id_valid),
        .overrun                (overrun),
        .mram_start             (mram_start),
        .mram_write             (mram_write),
        .mram_ready             (mram_ready),
        .mram_pulse_id_to_write (mram_pulse_id_to_write),
        .mram_pulse_id_read     (mram_pulse_id_read)
    );

    // MRAM store model
    logic [63:0] mem_init = 64'd0;
    logic        preload_en = 1'b1;
    int          m_lat = 3;
    logic [63:0] mem = 64'd0;
    logic        m_busy = 1'b0;
    logic        m_ready = 1'b1;
    int          m_cnt = 0;
    logic        m_op_write = 1'b0;
    logic [63:0] m_op_data = 64'd0;
    logic [63:0] m_rd = 64'd0;
    int          rd_starts = 0;
    int          wr_starts = 0;
    logic        last_start_write = 1'b0;
    logic        const_err = 1'b0;

    assign mram_ready         = m_ready;
    assign mram_pulse_id_read = m_rd;

    always @(posedge clk) begin
        if (reset) begin
            m_busy  <= 1'b0;
            m_ready <= 1'b1;
            m_cnt   <= 0;
            if (preload_en) mem <= mem_init;
        end else if (!m_busy && mram_start) begin
            m_busy           <= 1'b1;
            m_ready          <= 1'b0;
            m_cnt            <= m_lat;
            m_op_write       <= mram_write;
            m_op_data        <= mram_pulse_id_to_write;
            last_start_write <= mram_write;
            if (mram_write) wr_starts <= wr_starts + 1;
            else            rd_starts <= rd_starts + 1;
        end else if (m_busy) begin
            if (m_op_write && (mram_pulse_id_to_write !== m_op_data)) const_err <= 1'b1;
            if (m_cnt == 0) begin
                m_busy  <= 1'b0;
                m_ready <= 1'b1;
                if (m_op_write) mem <= m_op_data;
                else            m_rd <= mem;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        else begin
            n_pass++;
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic boot(input logic [63:0] val, input int lat);
        @(negedge clk);
        reset = 1'b1;
        preload_en = 1'b1;
        mem_init = val;
        m_lat = lat;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!pulse_id_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, {63'd0, pulse_id_valid}, 64'd1);
    endtask

    task automatic wait_quiet(input string tag);
        int q = 0;
        int n = 0;
        while (q < 4 && n < 3000) begin
            @(negedge clk);
            if (!m_busy && mram_ready && !mram_start) q++;
            else q = 0;
            n++;
        end
        if (q < 4) chk({tag, "_quiet_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic pulse(input logic t, input logic l, input logic [63:0] v);
        @(negedge clk);
        tick = t;
        load = l;
        load_value = v;
        @(negedge clk);
        tick = 1'b0;
        load = 1'b0;
    endtask

    int rd0, wr0, n;

    initial begin
        // 1: restore 0x1234 -> 0x1235, written back once
        boot(64'h1234, 3);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_pulse_id", pulse_id, 64'd0);
        chk("rst_valid", {63'd0, pulse_id_valid}, 64'd0);
        chk("rst_overrun", {63'd0, overrun}, 64'd0);
        chk("rst_start", {63'd0, mram_start}, 64'd0);
        chk("rst_write", {63'd0, mram_write}, 64'd0);
        chk("rst_wr_data", mram_pulse_id_to_write, 64'd0);
        rd0 = rd_starts;
        wr0 = wr_starts;
        reset = 1'b0;
        wait_valid("t1");
        chk("t1_pulse_id", pulse_id, 64'h1235);
        wait_quiet("t1");
        chk("t1_reads", 64'(rd_starts - rd0), 64'd1);
        chk("t1_writes", 64'(wr_starts - wr0), 64'd1);
        chk("t1_write_flag", {63'd0, last_start_write}, 64'd1);
        chk("t1_mem", mem, 64'h1235);

        // 2: erased MRAM; ticks/load before valid ignored
        boot('1, 20);
        pulse(1'b1, 1'b0, 64'd0);
        pulse(1'b0, 1'b1, 64'h77);
        pulse(1'b1, 1'b0, 64'd0);
        chk("t2_not_valid_yet", {63'd0, pulse_id_valid}, 64'd0);
        wait_valid("t2");
        chk("t2_pulse_id", pulse_id, 64'h1);
        wait_quiet("t2");
        chk("t2_mem", mem, 64'h1);
        chk("t2_overrun", {63'd0, overrun}, 64'd0);

        // 3: restored 0x10, three widely spaced ticks
        boot(64'h0F, 3);
        wait_valid("t3");
        chk("t3_restore", pulse_id, 64'h10);
        wait_quiet("t3a");
        pulse(1'b1, 1'b0, 64'd0);
        chk("t3_tick1", pulse_id, 64'h11);
        repeat (200) @(negedge clk);
        pulse(1'b1, 1'b0, 64'd0);
        chk("t3_tick2", pulse_id, 64'h12);
        repeat (200) @(negedge clk);
        pulse(1'b1, 1'b0, 64'd0);
        chk("t3_tick3", pulse_id, 64'h13);
        wait_quiet("t3b");
        chk("t3_mem", mem, 64'h13);
        chk("t3_overrun", {63'd0, overrun}, 64'd0);

        // 4: slow writes, ticks 50 cycles apart -> overrun, latest value kept
        boot(64'h20, 200);
        wait_valid("t4");
        wait_quiet("t4a");
        wr0 = wr_starts;
        @(negedge clk);
        const_err = 1'b0;
        @(negedge clk);
        tick = 1'b1; @(negedge clk); tick = 1'b0;
        repeat (49) @(negedge clk);
        tick = 1'b1; @(negedge clk); tick = 1'b0;
        chk("t4_no_overrun_yet", {63'd0, overrun}, 64'd0);
        repeat (49) @(negedge clk);
        tick = 1'b1; @(negedge clk); tick = 1'b0;
        chk("t4_overrun", {63'd0, overrun}, 64'd1);
        wait_quiet("t4b");
        chk("t4_pulse_id", pulse_id, 64'h24);
        chk("t4_mem", mem, 64'h24);
        chk("t4_writes", 64'(wr_starts - wr0), 64'd2);
        chk("t4_data_stable", {63'd0, const_err}, 64'd0);

        // 5: wrap at all-ones; load beats simultaneous tick
        boot(64'h0, 3);
        wait_valid("t5");
        wait_quiet("t5a");
        pulse(1'b0, 1'b1, '1);
        chk("t5_load", pulse_id, '1);
        wait_quiet("t5b");
        chk("t5_mem_ones", mem, '1);
        pulse(1'b1, 1'b0, 64'd0);
        chk("t5_wrap", pulse_id, 64'd0);
        wait_quiet("t5c");
        chk("t5_mem_zero", mem, 64'd0);
        pulse(1'b1, 1'b1, 64'hABCD);
        chk("t5_load_tick", pulse_id, 64'hABCD);
        wait_quiet("t5d");
        chk("t5_mem_abcd", mem, 64'hABCD);

        // 6: reset during a write; write aborted, restore rereads MRAM
        boot(64'h40, 50);
        wait_valid("t6");
        wait_quiet("t6a");
        chk("t6_mem_boot", mem, 64'h41);
        preload_en = 1'b0;
        pulse(1'b1, 1'b0, 64'd0);
        n = 0;
        while (!(m_busy && m_op_write) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6_in_write", {63'd0, m_busy && m_op_write}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_pulse_id", pulse_id, 64'd0);
        chk("t6_rst_valid", {63'd0, pulse_id_valid}, 64'd0);
        chk("t6_rst_start", {63'd0, mram_start}, 64'd0);
        chk("t6_rst_wr_data", mram_pulse_id_to_write, 64'd0);
        rd0 = rd_starts;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_valid("t6b");
        chk("t6_reread", 64'(rd_starts - rd0), 64'd1);
        chk("t6_pulse_id", pulse_id, 64'h42);
        wait_quiet("t6c");
        chk("t6_mem", mem, 64'h42);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
